// File: rtl/an_decode_packer.sv
// Bit-serial AN-code decoder: divides each codeword by A, checks the remainder,
// and packs ten signed quotients into one frame. Optional: ANDEC_POISON_ON_ERR_EN.
module an_decode_packer #(
  parameter int DATA_WIDTH = 24,
  parameter int A          = 29,
  parameter int A_WIDTH    = 5,
  parameter int CODE_WIDTH = 29,
  parameter int N_CLASS    = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CODE_WIDTH-1:0]         in_code,
  output logic [DATA_WIDTH*N_CLASS-1:0] layer_out,
  output logic                          valid,
  output logic [N_CLASS-1:0]            err_mask,
  output logic                          err
);

  localparam int REM_W = A_WIDTH + 1;
  localparam int CNT_W = $clog2(CODE_WIDTH);
  localparam int IDX_W = $clog2(N_CLASS);
  localparam logic [CODE_WIDTH-1:0] NEG_LIM = CODE_WIDTH'(64'd1 << (DATA_WIDTH - 1));
  localparam logic [CODE_WIDTH-1:0] POS_LIM = NEG_LIM - 1'b1;
  localparam logic [DATA_WIDTH-1:0] POISON  = DATA_WIDTH'(64'd1 << (DATA_WIDTH - 1));

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_STORE, S_DONE} state_t;

  state_t                                 state_q, state_d;
  logic                                   sign_q, sign_d;
  logic [CODE_WIDTH-1:0]                  mag_q, mag_d;
  logic [REM_W-1:0]                       rem_q, rem_d;
  logic [CODE_WIDTH-1:0]                  quo_q, quo_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic [N_CLASS-1:0][DATA_WIDTH-1:0]     buf_q, buf_d;
  logic [N_CLASS-1:0]                     berr_q, berr_d;
  logic [DATA_WIDTH*N_CLASS-1:0]          layer_q, layer_d;
  logic [N_CLASS-1:0]                     err_mask_q, err_mask_d;
  logic                                   err_q, err_d;

  logic [REM_W-1:0]      shifted;
  logic                  rem_ge;
  logic [CODE_WIDTH-1:0] q_signed;
  logic                  ovf;
  logic                  slot_err;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    berr_d     = berr_q;
    layer_d    = layer_q;
    err_mask_d = err_mask_q;
    err_d      = err_q;

    shifted  = {rem_q[A_WIDTH-1:0], mag_q[CODE_WIDTH-1]};
    rem_ge   = (shifted >= REM_W'(A));
    q_signed = sign_q ? ('0 - quo_q) : quo_q;
    ovf      = sign_q ? (quo_q > NEG_LIM) : (quo_q > POS_LIM);
    slot_err = (rem_q != '0) || ovf;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = in_code[CODE_WIDTH-1];
          mag_d   = in_code[CODE_WIDTH-1] ? ('0 - in_code) : in_code;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_W'(CODE_WIDTH - 1);
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = rem_ge ? (shifted - REM_W'(A)) : shifted;
        quo_d = {quo_q[CODE_WIDTH-2:0], rem_ge};
        mag_d = {mag_q[CODE_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_STORE;
      end
      S_STORE: begin
`ifdef ANDEC_POISON_ON_ERR_EN
        buf_d[idx_q] = slot_err ? POISON : q_signed[DATA_WIDTH-1:0];
`else
        buf_d[idx_q] = q_signed[DATA_WIDTH-1:0];
`endif
        berr_d[idx_q] = slot_err;
        idx_d         = idx_q + 1'b1;
        if (idx_q == IDX_W'(N_CLASS - 1)) begin
          // Publish here so the new frame is visible in the same cycle as valid.
          layer_d    = buf_d;
          err_mask_d = berr_d;
          err_d      = |berr_d;
          state_d    = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        idx_d   = '0;
        berr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      // NOTE: the slot buffer is reset because a reset must discard any partial frame.
      buf_q      <= '0;
      berr_q     <= '0;
      layer_q    <= '0;
      err_mask_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      berr_q     <= berr_d;
      layer_q    <= layer_d;
      err_mask_q <= err_mask_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign valid     = (state_q == S_DONE);
  assign layer_out = layer_q;
  assign err_mask  = err_mask_q;
  assign err       = err_q;

endmodule

// File: tb/tb_an_decode_packer.sv
// Directed self-checking bench for an_decode_packer; expectations follow the
// ANDEC_POISON_ON_ERR_EN setting of the build.
module tb_an_decode_packer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [28:0]  in_code;
  logic [239:0] layer_out;
  logic         valid;
  logic [9:0]   err_mask;
  logic         err;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  logic [28:0]  codes    [10];
  logic [23:0]  exp_slot [10];
  logic [239:0] prev_frame;
  int           vbase;

  an_decode_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .layer_out (layer_out),
    .valid     (valid),
    .err_mask  (err_mask),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (valid) vcount <= vcount + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [239:0] pack_exp();
    logic [239:0] r;
    for (int i = 0; i < 10; i++) r[i*24 +: 24] = exp_slot[i];
    return r;
  endfunction

  // Waits (bounded) for in_ready, then presents one codeword for one edge.
  task automatic send(input logic [28:0] code);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    in_code  = code;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_frame(input string name);
    int n;
    for (int i = 0; i < 10; i++) send(codes[i]);
    n = 1;
    while (!valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, n, 31);
    check({name, "_layer_out"}, layer_out, pack_exp());
    @(posedge clk);
    #1;
    check({name, "_valid_pulse"}, valid, 1'b0);
    check({name, "_layer_hold"}, layer_out, pack_exp());
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_layer_out", layer_out, 240'd0);
    check("rst_err_mask", err_mask, 10'd0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);

    // Frame 1: scores 1..10, each times 29.
    for (int i = 0; i < 10; i++) begin
      codes[i]    = 29'(29 * (i + 1));
      exp_slot[i] = 24'(i + 1);
    end
    send(codes[0]);
    check("busy_after_accept", in_ready, 1'b0);
    for (int i = 0; i < 9; i++) codes[i] = codes[i + 1];
    for (int i = 0; i < 9; i++) send(codes[i]);
    begin
      int n = 1;
      while (!valid && n < 60) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("f1_latency", n, 31);
    end
    check("f1_layer_out", layer_out, pack_exp());
    check("f1_err_mask", err_mask, 10'h000);
    check("f1_err", err, 1'b0);
    check("f1_ready_in_done", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("f1_valid_pulse", valid, 1'b0);
    check("f1_vcount", vcount, 1);
    prev_frame = pack_exp();

    // Frame 2: sign, remainder and overflow boundaries.
    for (int i = 0; i < 10; i++) begin
      codes[i]    = '0;
      exp_slot[i] = '0;
    end
    codes[0] = 29'h0E7FFFE3;  exp_slot[0] = 24'h7FFFFF;  // 29*(2^23-1)
    codes[3] = 29'h1FFFFFA9;  exp_slot[3] = 24'hFFFFFD;  // -87
    codes[5] = 29'h0000092;                               // 146, remainder 1
    codes[7] = 29'h0E800000;  exp_slot[7] = 24'h800000;  // 29*2^23, positive overflow
    codes[8] = 29'h11800000;  exp_slot[8] = 24'h800000;  // -29*2^23, exact negative limit
    codes[9] = 29'h10000000;                              // -2^28
`ifdef ANDEC_POISON_ON_ERR_EN
    exp_slot[5] = 24'h800000;
    exp_slot[9] = 24'h800000;
`else
    exp_slot[5] = 24'h000005;
    exp_slot[9] = 24'h72C235;
`endif
    for (int i = 0; i < 3; i++) send(codes[i]);
    check("f2_hold_prev_frame", layer_out, prev_frame);
    check("f2_hold_err", err, 1'b0);
    for (int i = 0; i < 7; i++) codes[i] = codes[i + 3];
    for (int i = 0; i < 7; i++) send(codes[i]);
    begin
      int n = 1;
      while (!valid && n < 60) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("f2_latency", n, 31);
    end
    check("f2_layer_out", layer_out, pack_exp());
    check("f2_err_mask", err_mask, 10'h2A0);
    check("f2_err", err, 1'b1);
    @(posedge clk);
    #1;
    check("f2_err_hold", err_mask, 10'h2A0);

    // Reset in the middle of the 4th division; the partial frame must vanish.
    vbase = vcount;
    for (int i = 0; i < 4; i++) send(29'(29 * (100 + i)));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_layer_out", layer_out, 240'd0);
    check("midrst_err", err, 1'b0);
    check("midrst_idle", in_ready, 1'b1);

    // Frame 3: fresh frame after reset, class 7 largest.
    for (int i = 0; i < 10; i++) begin
      codes[i]    = 29'(29 * (20 + i));
      exp_slot[i] = 24'(20 + i);
    end
    codes[7]    = 29'(29 * 1000);
    exp_slot[7] = 24'd1000;
    run_frame("f3");
    check("f3_err_mask", err_mask, 10'h000);
    check("f3_single_valid", vcount - vbase, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
